// File: rtl/axil_pkg.sv
// Shared response codes, state encodings and counter sizing for the AXI-Lite SRAM slave.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Wide enough for the largest read wait count (15).
    localparam int RD_CNT_W = 4;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/axil_sram_mem.sv
// Word-addressed storage: one registered read port and one byte-enabled synchronous write port.
module axil_sram_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [DATA_W-1:0]          rd_data,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_strb
);

    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // No reset: contents survive rst. A same-edge write to the read word is not seen by that read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_strb[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axil_sram.sv
// AXI4-Lite slave in front of a single-ported-per-direction SRAM; independent read and write FSMs.
//
// state     | meaning
// R_IDLE    | arready high, waiting for an AR handshake
// R_WAIT    | memory word sampled, counting down the added read latency
// R_RESP    | rvalid high, rdata/rresp held until rready
// W_COLLECT | accepting AW and W in any order; commits once both are held
// W_RESP    | bvalid high, bresp held until bready
module axil_sram
    import axil_pkg::*;
#(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 1024,
    parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
    parameter int                RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp
);

    localparam int                BYTES = DATA_W / 8;
    localparam int                OFF_W = $clog2(BYTES);
    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   SPAN  = (ADDR_W + 1)'(DEPTH * BYTES);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >= BASE) && ({1'b0, a - BASE} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> OFF_W);
    endfunction

    rd_state_e            rd_state_q, rd_state_d;
    logic [RD_CNT_W-1:0]  rd_cnt_q,   rd_cnt_d;
    logic                 ar_err_q,   ar_err_d;
    logic [DATA_W-1:0]    rdata_q,    rdata_d;
    logic [1:0]           rresp_q,    rresp_d;
    logic                 arready_q,  arready_d;
    logic                 rvalid_q,   rvalid_d;

    wr_state_e            wr_state_q, wr_state_d;
    logic                 aw_held_q,  aw_held_d;
    logic                 w_held_q,   w_held_d;
    logic [IDX_W-1:0]     aw_idx_q,   aw_idx_d;
    logic                 aw_err_q,   aw_err_d;
    logic [DATA_W-1:0]    w_data_q,   w_data_d;
    logic [BYTES-1:0]     w_strb_q,   w_strb_d;
    logic                 awready_q,  awready_d;
    logic                 wready_q,   wready_d;
    logic                 bvalid_q,   bvalid_d;
    logic [1:0]           bresp_q,    bresp_d;

    logic                 mem_re;
    logic                 mem_we;
    logic [DATA_W-1:0]    mem_rdata;

    // The memory word is sampled on the AR edge; R_WAIT always spans RD_LAT+1 edges so that
    // rvalid rises exactly RD_LAT+1 cycles after the handshake, including RD_LAT=0.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        ar_err_d   = ar_err_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        mem_re     = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    mem_re     = 1'b1;
                    ar_err_d   = !in_range(araddr);
                    rd_cnt_d   = RD_CNT_W'(RD_LAT);
                    rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_cnt_q == '0) begin
                    rdata_d    = ar_err_q ? '0 : mem_rdata;
                    rresp_d    = ar_err_q ? RESP_SLVERR : RESP_OKAY;
                    rd_state_d = R_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q - 1'b1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        arready_d = (rd_state_d == R_IDLE);
        rvalid_d  = (rd_state_d == R_RESP);
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        aw_err_d   = aw_err_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        unique case (wr_state_q)
            W_COLLECT: begin
                if (awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = word_idx(awaddr);
                    aw_err_d  = !in_range(awaddr);
                end
                if (wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                end
                // Commit on the edge where the second half arrives, using the freshly captured values.
                if (aw_held_d && w_held_d) begin
                    mem_we     = !aw_err_d;
                    bresp_d    = aw_err_d ? RESP_SLVERR : RESP_OKAY;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_COLLECT;
                end
            end
            default: wr_state_d = W_COLLECT;
        endcase
        awready_d = (wr_state_d == W_COLLECT) && !aw_held_d;
        wready_d  = (wr_state_d == W_COLLECT) && !w_held_d;
        bvalid_d  = (wr_state_d == W_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
            ar_err_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            wr_state_q <= W_COLLECT;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            aw_err_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            ar_err_q   <= ar_err_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            aw_err_q   <= aw_err_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    // A commit racing with rst is dropped so an abandoned write never reaches the array.
    axil_sram_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rd_en   (mem_re),
        .rd_idx  (word_idx(araddr)),
        .rd_data (mem_rdata),
        .wr_en   (mem_we && !rst),
        .wr_idx  (aw_idx_d),
        .wr_data (w_data_d),
        .wr_strb (w_strb_d)
    );

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axil_sram.sv
// Self-checking bench for axil_sram: scoreboard queues of expected R/B responses, one task per scenario.
module tb_axil_sram;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        arvalid = 0, arready, rvalid, rready = 0;
    logic [31:0] araddr = 0, rdata;
    logic [1:0]  rresp;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
    logic [31:0] awaddr = 0, wdata = 0;
    logic [3:0]  wstrb = 0;
    logic [1:0]  bresp;

    logic        z_arvalid = 0, z_arready, z_rvalid, z_rready = 0;
    logic [31:0] z_araddr = 0, z_rdata;
    logic [1:0]  z_rresp;
    logic        z_awvalid = 0, z_awready, z_wvalid = 0, z_wready, z_bvalid, z_bready = 0;
    logic [31:0] z_awaddr = 0, z_wdata = 0;
    logic [3:0]  z_wstrb = 0;
    logic [1:0]  z_bresp;

    axil_sram #(.RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    axil_sram #(.RD_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .arvalid(z_arvalid), .arready(z_arready), .araddr(z_araddr),
        .rvalid(z_rvalid), .rready(z_rready), .rdata(z_rdata), .rresp(z_rresp),
        .awvalid(z_awvalid), .awready(z_awready), .awaddr(z_awaddr),
        .wvalid(z_wvalid), .wready(z_wready), .wdata(z_wdata), .wstrb(z_wstrb),
        .bvalid(z_bvalid), .bready(z_bready), .bresp(z_bresp)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    rexp_t       rd_q[$];
    logic [1:0]  b_q[$];
    logic [31:0] model [int];

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8000_1000);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - 32'h8000_0000) >> 2);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (in_rng(a)) begin
            w = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            model[widx(a)] = w;
            b_q.push_back(2'b00);
        end else begin
            b_q.push_back(2'b10);
        end
    endtask

    task automatic model_read(input logic [31:0] a);
        rexp_t e;
        if (in_rng(a)) begin
            e.data = model[widx(a)];
            e.resp = 2'b00;
        end else begin
            e.data = 32'h0;
            e.resp = 2'b10;
        end
        rd_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is at #1 after an edge. lat = edges from the AR handshake edge to first rvalid.
    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                            output int lat);
        logic hs;
        int   g;
        arvalid = 1'b1;
        araddr  = a;
        g = 0;
        do begin
            hs = arready;
            tick();
            g++;
        end while (!hs && g < 50);
        arvalid = 1'b0;
        if (!hs) begin
            n_cmp++; n_bad++;
            $display("FAIL ar_timeout: arready never seen, required handshake");
        end
        lat = 0;
        while (!rvalid && lat < 50) begin
            tick();
            lat++;
        end
        d = rdata;
        r = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, output logic [1:0] r, output logic early,
                             output logic on_time);
        bit   awd = 0, wd = 0;
        logic awr, wr;
        int   c = 0;
        int   aw_start = (lead > 0) ? lead : 0;
        int   w_start  = (lead < 0) ? -lead : 0;
        early = 1'b0;
        while (!(awd && wd) && c < 50) begin
            awvalid = !awd && (c >= aw_start);
            wvalid  = !wd && (c >= w_start);
            awaddr  = a;
            wdata   = d;
            wstrb   = s;
            awr     = awready;
            wr      = wready;
            early   = early | bvalid;
            tick();
            if (awvalid && awr) awd = 1;
            if (wvalid && wr) wd = 1;
            c++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(awd && wd)) begin
            n_cmp++; n_bad++;
            $display("FAIL w_timeout: aw_done=%0d w_done=%0d, required both", awd, wd);
        end
        on_time = bvalid;
        c = 0;
        while (!bvalid && c < 20) begin
            tick();
            c++;
        end
        r = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp} !== 41'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({arready, awready, wready, z_arready} !== 4'b1111) begin
            n_bad++;
            $display("FAIL ready_after_reset: got %b, required 1111",
                     {arready, awready, wready, z_arready});
        end
    endtask

    task automatic wr_check(input string nm, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int lead);
        logic [1:0] r, e;
        logic       early, on_time;
        model_write(a, d, s);
        axi_write(a, d, s, lead, r, early, on_time);
        e = b_q.pop_front();
        n_cmp++;
        if (r !== e) begin
            n_bad++;
            $display("FAIL %s bresp: got %b, required %b", nm, r, e);
        end
        n_cmp++;
        if ({early, on_time} !== 2'b01) begin
            n_bad++;
            $display("FAIL %s b_timing: early=%b next=%b, required early=0 next=1", nm, early, on_time);
        end
    endtask

    task automatic rd_check(input string nm, input logic [31:0] a, input int exp_lat);
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        rexp_t       e;
        model_read(a);
        axi_read(a, d, r, lat);
        e = rd_q.pop_front();
        n_cmp++;
        if ({d, r} !== {e.data, e.resp}) begin
            n_bad++;
            $display("FAIL %s rdata/rresp: got %h/%b, required %h/%b", nm, d, r, e.data, e.resp);
        end
        if (exp_lat > 0) begin
            n_cmp++;
            if (lat != exp_lat) begin
                n_bad++;
                $display("FAIL %s latency: got %0d, required %0d", nm, lat, exp_lat);
            end
        end
    endtask

    task automatic test_read_latency();
        wr_check("init_10", 32'h8000_0010, 32'hA5A5_0010, 4'hF, 0);
        rd_check("read_10", 32'h8000_0010, 2);
    endtask

    task automatic test_w_before_aw();
        wr_check("w_first", 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 3);
        rd_check("read_04", 32'h8000_0004, 2);
    endtask

    task automatic test_strobe();
        wr_check("fill_08", 32'h8000_0008, 32'hFFFF_FFFF, 4'hF, 0);
        wr_check("strb_08", 32'h8000_0008, 32'h1122_3344, 4'h5, -2);
        rd_check("read_08", 32'h8000_0008, 2);
        n_cmp++;
        if (model[2] !== 32'hFF22_FF44) begin
            n_bad++;
            $display("FAIL strobe_model: got %h, required ff22ff44", model[2]);
        end
    endtask

    task automatic test_out_of_range();
        wr_check("init_000", 32'h8000_0000, 32'h0000_AAAA, 4'hF, 0);
        wr_check("init_ffc", 32'h8000_0FFC, 32'h0000_BBBB, 4'hF, 0);
        rd_check("oor_rd_0", 32'h0000_0000, 2);
        rd_check("oor_rd_hi", 32'h8000_1000, 2);
        wr_check("oor_wr_9", 32'h9000_0000, 32'h1234_5678, 4'hF, 0);
        wr_check("oor_wr_lo", 32'h7FFF_FFFC, 32'h8765_4321, 4'hF, 1);
        rd_check("keep_000", 32'h8000_0000, 2);
        rd_check("keep_ffc", 32'h8000_0FFC, 2);
    endtask

    task automatic test_r_backpressure();
        logic [31:0] first;
        rexp_t       e;
        int          g;
        model_read(32'h8000_0004);
        arvalid = 1'b1;
        araddr  = 32'h8000_0004;
        tick();
        arvalid = 1'b0;
        g = 0;
        while (!rvalid && g < 20) begin
            tick();
            g++;
        end
        first = rdata;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({rvalid, arready, rdata} !== {1'b1, 1'b0, first}) begin
                n_bad++;
                $display("FAIL stall_%0d: rvalid=%b arready=%b rdata=%h, required 1/0/%h",
                         i, rvalid, arready, rdata, first);
            end
            tick();
        end
        e = rd_q.pop_front();
        n_cmp++;
        if ({rdata, rresp} !== {e.data, e.resp}) begin
            n_bad++;
            $display("FAIL stall_data: got %h/%b, required %h/%b", rdata, rresp, e.data, e.resp);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic test_rdlat0();
        int g;
        z_arvalid = 1'b1;
        z_araddr  = 32'h0000_0000;
        tick();
        z_arvalid = 1'b0;
        g = 0;
        while (!z_rvalid && g < 20) begin
            tick();
            g++;
        end
        n_cmp++;
        if ({g[7:0], z_rdata, z_rresp} !== {8'd1, 32'h0, 2'b10}) begin
            n_bad++;
            $display("FAIL rdlat0: lat=%0d rdata=%h rresp=%b, required 1/0/10", g, z_rdata, z_rresp);
        end
        z_rready = 1'b1;
        tick();
        z_rready = 1'b0;
    endtask

    task automatic test_same_edge();
        logic [31:0] d;
        logic [1:0]  r;
        int          g;
        rexp_t       e;
        wr_check("init_20", 32'h8000_0020, 32'h0BAD_F00D, 4'hF, 0);
        model_read(32'h8000_0020);
        model_write(32'h8000_0020, 32'h600D_CAFE, 4'hF);
        wvalid = 1'b1; wdata = 32'h600D_CAFE; wstrb = 4'hF;
        tick();
        wvalid  = 1'b0;
        awvalid = 1'b1; awaddr = 32'h8000_0020;
        arvalid = 1'b1; araddr = 32'h8000_0020;
        tick();
        awvalid = 1'b0;
        arvalid = 1'b0;
        n_cmp++;
        if (bvalid !== 1'b1 || bresp !== b_q.pop_front()) begin
            n_bad++;
            $display("FAIL same_edge_b: bvalid=%b bresp=%b, required 1/00", bvalid, bresp);
        end
        bready = 1'b1;
        g = 0;
        while (!rvalid && g < 20) begin
            tick();
            bready = 1'b0;
            g++;
        end
        d = rdata; r = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        e = rd_q.pop_front();
        n_cmp++;
        if ({d, r} !== {e.data, e.resp}) begin
            n_bad++;
            $display("FAIL same_edge_old: got %h/%b, required %h/%b", d, r, e.data, e.resp);
        end
        rd_check("same_edge_new", 32'h8000_0020, 2);
    endtask

    task automatic test_reset_mid();
        awvalid = 1'b1; awaddr = 32'h8000_0004;
        tick();
        wvalid = 1'b1; wdata = 32'h5555_5555; wstrb = 4'hF;
        rst = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n_cmp++;
        if ({arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp} !== 41'h0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %h, required 0",
                     {arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp});
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({arready, awready, wready} !== 3'b111) begin
            n_bad++;
            $display("FAIL mid_reset_ready: got %b, required 111", {arready, awready, wready});
        end
        rd_check("mid_reset_keep", 32'h8000_0004, 2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int k = 0; k < 8; k++)
            wr_check("b2b_fill", 32'h8000_0040 + 32'(4 * k), $urandom, 4'hF, 0);
        for (int k = 0; k < 12; k++) begin
            a = 32'h8000_0040 + 32'(4 * $urandom_range(0, 7));
            wr_check("b2b_wr", a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2);
            rd_check("b2b_rd", 32'h8000_0040 + 32'(4 * $urandom_range(0, 7)), 2);
        end
        for (int k = 0; k < 8; k++)
            rd_check("b2b_all", 32'h8000_0040 + 32'(4 * k), 2);
    endtask

    initial begin
        #1;
        test_reset();
        test_read_latency();
        test_w_before_aw();
        test_strobe();
        test_out_of_range();
        test_r_backpressure();
        test_rdlat0();
        test_same_edge();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
